// File: rtl/sar_search.sv
// Successive-approximation search controller: binary-searches the N-bit unsigned
// range by driving candidates to an external magnitude comparator and reading its flags.
module sar_search #(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] probe,
    input  logic         smaller,
    input  logic         equal,
    input  logic         greater,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        EVAL,
        DONE
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [2:0]   flags;

    assign flags = {smaller, equal, greater};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            probe  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            result <= '0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo     <= '0;
                        hi     <= '1;
                        found  <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= PROBE;
                    end
                end
                PROBE: begin
                    // Midpoint written as an offset from lo so it never exceeds N bits.
                    probe <= lo + ((hi - lo) >> 1);
                    state <= EVAL;
                end
                EVAL: begin
                    case (flags)
                        3'b010: begin
                            result <= probe;
                            found  <= 1'b1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                        3'b100: begin
                            if (probe == hi) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                lo    <= probe + ONE;
                                state <= PROBE;
                            end
                        end
                        3'b001: begin
                            if (probe == lo) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                hi    <= probe - ONE;
                                state <= PROBE;
                            end
                        end
                        default: begin
                            // Inconsistent comparator flags: give up without a match.
                            result <= '0;
                            found  <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator with fault modes, search-level model
// checked every cycle, plus directed searches with hand-computed outcomes.
module tb_sar_search;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         smaller, equal, greater;
    logic         busy, done, found;
    logic [N-1:0] probe, result;

    int target = 0;
    int mode = 0;  // 0 real, 1 no flags, 2 smaller+greater, 3 always smaller, 4 always greater
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sar_search #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .probe(probe),
        .smaller(smaller), .equal(equal), .greater(greater),
        .busy(busy), .done(done), .found(found), .result(result)
    );

    always_comb begin
        smaller = 1'b0;
        equal   = 1'b0;
        greater = 1'b0;
        case (mode)
            0: begin
                smaller = int'(probe) < target;
                equal   = int'(probe) == target;
                greater = int'(probe) > target;
            end
            2: begin
                smaller = 1'b1;
                greater = 1'b1;
            end
            3: smaller = 1'b1;
            4: greater = 1'b1;
            default: ;
        endcase
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Whole-search model: list of probes plus final outcome.
    function automatic void model_search(input int md, input int t, output int pl[$],
                                         output logic f, output int r);
        int lo;
        int hi;
        int p;
        lo = 0;
        hi = (1 << N) - 1;
        pl = {};
        f = 1'b0;
        r = 0;
        while (1) begin
            p = (lo + hi) / 2;
            pl.push_back(p);
            if (md == 1 || md == 2) return;
            if (md == 0 && p == t) begin
                f = 1'b1;
                r = p;
                return;
            end
            if (md == 3 || (md == 0 && p < t)) begin
                if (p == hi) return;
                lo = p + 1;
            end else begin
                if (p == lo) return;
                hi = p - 1;
            end
        end
    endfunction

    // Model timeline: rel counts edges since start acceptance.
    logic m_ready = 1'b0, m_active = 1'b0, m_fin_f = 1'b0, m_hold_f = 1'b0;
    int   m_rel = 0, m_k = 0, m_fin_r = 0, m_hold_r = 0, m_prev = 0;
    int   m_pl[$];

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_ready  = 1'b1;
            m_active = 1'b0;
            m_prev   = 0;
            m_hold_f = 1'b0;
            m_hold_r = 0;
        end else if (m_ready) begin
            if (m_active) begin
                if (m_rel == 2 * m_k) begin
                    m_active = 1'b0;
                    m_prev   = m_pl[m_k-1];
                    m_hold_f = m_fin_f;
                    m_hold_r = m_fin_r;
                end else begin
                    m_rel++;
                end
            end else if (start) begin
                model_search(mode, target, m_pl, m_fin_f, m_fin_r);
                m_k      = m_pl.size();
                m_rel    = 0;
                m_active = 1'b1;
            end
        end
    end

    initial forever begin
        int e_busy, e_done, e_probe, e_found, e_result;
        @(negedge clk);
        if (m_ready) begin
            if (m_active) begin
                e_busy   = 1;
                e_done   = (m_rel == 2 * m_k) ? 1 : 0;
                e_probe  = (m_rel == 0) ? m_prev : m_pl[(m_rel + 1) / 2 - 1];
                e_found  = (m_rel == 2 * m_k) ? int'(m_fin_f) : 0;
                e_result = (m_rel == 2 * m_k) ? m_fin_r : 0;
            end else begin
                e_busy   = 0;
                e_done   = 0;
                e_probe  = m_prev;
                e_found  = int'(m_hold_f);
                e_result = m_hold_r;
            end
            check("cyc_busy", int'(busy), e_busy);
            check("cyc_done", int'(done), e_done);
            check("cyc_probe", int'(probe), e_probe);
            check("cyc_found", int'(found), e_found);
            check("cyc_result", int'(result), e_result);
        end
    end

    // Called at #1 after a posedge with the DUT idle; returns after the accepting edge.
    task automatic launch();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles from the accepting edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input int t, input int md, input int ek, input int ef, input int er,
                       input string nm);
        int n;
        int pl[$];
        logic mf;
        int mr;
        target = t;
        mode = md;
        model_search(md, t, pl, mf, mr);
        check({nm, "_model_probes"}, pl.size(), ek);
        check({nm, "_model_found"}, int'(mf), ef);
        launch();
        wait_done(n);
        check({nm, "_latency"}, n, 2 * ek);
        check({nm, "_found"}, int'(found), ef);
        check({nm, "_result"}, int'(result), er);
        $display("search %s: target=%0d mode=%0d probes=%0d latency=%0d found=%0d result=%0d",
                 nm, t, md, pl.size(), n, found, result);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int pl[$];
        logic mf;
        int mr;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_probe", int'(probe), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        model_search(0, 4095, pl, mf, mr);
        check("model_4095_p2", pl[1], 3071);
        check("model_4095_p3", pl[2], 3583);
        check("model_4095_last", pl[12], 4095);
        model_search(0, 0, pl, mf, mr);
        check("model_0_p2", pl[1], 1023);
        check("model_0_last", pl[11], 0);

        run(2047, 0, 1, 1, 2047, "t2047");
        run(4095, 0, 13, 1, 4095, "t4095");
        run(0, 0, 12, 1, 0, "t0");
        run(100, 1, 1, 0, 0, "no_flags");
        run(100, 2, 1, 0, 0, "two_flags");
        run(0, 3, 13, 0, 0, "always_smaller");
        run(0, 4, 12, 0, 0, "always_greater");

        // Target 1234 with a second start pulse during the third probe's EVAL.
        target = 1234;
        mode = 0;
        launch();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        check("repulse_latency", n + 6, 24);
        check("repulse_result", int'(result), 1234);
        $display("search repulse: latency=%0d found=%0d result=%0d", n + 6, found, result);
        @(posedge clk);
        #1;

        // Reset during the fifth probe aborts with no done pulse.
        launch();
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_probe", int'(probe), 0);
        check("abort_done", int'(done), 0);
        $display("abort: busy=%0d done=%0d probe=%0d", busy, done, probe);
        repeat (3) @(posedge clk);
        #1;
        run(1234, 0, 12, 1, 1234, "t1234_after_abort");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
